instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the single-cycle CPU datapath. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers up to two fetched instructions. It presents one instruction per cycle to decode, whose low half-word (instr_o[15:0]) feeds the sign-extend stage. Branch/jump redirects flush the buffer and any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- imem_req_o  out  1  read request to instruction memory (registered)
- imem_addr_o  out  32  word-aligned read address; stable while imem_req_o=1 and not acked
- imem_ack_i  in  1  memory accepts/returns; sampled only while imem_req_o=1; may assert in the same cycle as req
- imem_data_i  in  32  instruction word, valid in the cycle imem_ack_i=1
- redirect_i  in  1  taken branch/jump from execute
- redirect_pc_i  in  32  new fetch address; bits [1:0] forced to 0 internally
- stall_i  in  1  decode cannot accept the head instruction this cycle
- instr_valid_o  out  1  head entry valid
- instr_o  out  32  head instruction; 0 when buffer empty
- pc_o  out  32  address of head instruction; 0 when buffer empty
- pc_plus4_o  out  32  pc_o + 4 mod 2^32; 0 when buffer empty

## Operation
- Buffer: 2-entry FIFO of {pc, instr}; count 0..2. Push on accepted ack (not discarded); pop when instr_valid_o=1 and stall_i=0; push and pop in the same cycle allowed, including at count=2 with pop.
- At most one memory request outstanding.
- FSM states:
  - IDLE: imem_req_o=0. Go REQ (addr=fetch_pc) when count_next<2 (count after this edge's push/pop).
  - REQ: imem_req_o=1. On ack: push {addr, data}, fetch_pc+=4; if count_next<2, stay REQ with the new addr (back-to-back), else go IDLE.
  - FLUSH: request in flight whose data is stale. Hold req and old addr until ack; discard data; then go REQ at fetch_pc if count_next<2, else IDLE.
- Redirect (priority over pop, push and issue): at the edge with redirect_i=1, clear the FIFO, set fetch_pc=redirect_pc_i & ~3.
  - In REQ without ack: go FLUSH.
  - In REQ with ack the same cycle: discard the data, go REQ at the redirect address.
  - In IDLE: go REQ at the redirect address.
  - In FLUSH: stay FLUSH; new target replaces the old one.
- fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no error.
- imem_req_o is never dropped while unacked, including during redirect.

## Timing
- Reset (async assert): state=IDLE, fetch_pc=RESET_PC, count=0, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0.
- First edge after rst_i deasserts: go REQ; imem_req_o=1 in cycle 1.
- Latency: ack in cycle N means instr_valid_o=1 in cycle N+1. Zero-wait memory gives one instruction per cycle sustained.
- Redirect at edge E with zero-wait memory, no flush needed: req to target in cycle E+1, target instruction valid in cycle E+2.
- Outputs are registered or decoded from registers only. There is no combinational path from any input to any output.

## Test plan
- Reset: RESET_PC=0x100, ack always 1, stall=0 -> addrs 0x100, 0x104, 0x108 on consecutive cycles; instr_valid_o rises 1 cycle after the first req; pc_plus4_o=pc_o+4.
- Backpressure: stall=1 from the start, ack=1 -> exactly 2 entries buffered, req drops to 0. Release stall -> entries pop in order, req resumes at 0x108.
- Redirect with wait-state memory: redirect to 0x2002 while req at 0x10C is unacked -> req holds 0x10C until ack, that data is never presented, next req at 0x2000, first valid pc_o=0x2000.
- Redirect coincident with ack and with pop -> buffer empty next cycle, acked data discarded, next req 0x2000.
- Wrap: redirect to 0xFFFF_FFF8 -> fetched pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; pc_plus4_o for 0xFFFF_FFFC is 0.
- Reset asserted mid-request with a full buffer -> all outputs at reset values immediately (async). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, req/ack instruction-memory reads and a
// 2-entry {pc, instr} buffer feeding decode; redirects flush buffer and in-flight data.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_pc    [2];
  logic [31:0] r_instr [2];
  logic        r_head;
  logic [1:0]  r_count, w_count_nxt;
  logic        w_req, w_ack, w_valid, w_pop, w_push, w_room;
  logic [31:0] w_target;

  assign w_target = {redirect_pc_i[31:2], 2'b00};
  assign w_req    = (r_state != S_IDLE);
  assign w_ack    = w_req & imem_ack_i;
  assign w_valid  = (r_count != 2'd0);
  assign w_pop    = w_valid & ~stall_i;
  // Only fresh (non-flushed) data is kept, and a redirect discards it too.
  assign w_push   = (r_state == S_REQ) & w_ack & ~redirect_i;

  always_comb begin
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    if (redirect_i)
      w_count_nxt = '0;
  end

  assign w_room = (w_count_nxt < 2'd2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    if (redirect_i) begin
      w_fetch_pc_nxt = w_target;
      if (r_state == S_IDLE || w_ack) begin
        w_state_nxt = S_REQ;
        w_addr_nxt  = w_target;
      end else begin
        // Unacked request must stay on the bus with its old address.
        w_state_nxt = S_FLUSH;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_room) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = r_fetch_pc;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_addr_nxt     = r_fetch_pc + 32'd4;
            if (!w_room)
              w_state_nxt = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (w_ack) begin
            if (w_room) begin
              w_state_nxt = S_REQ;
              w_addr_nxt  = r_fetch_pc;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_head     <= 1'b0;
      r_count    <= '0;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      if (redirect_i) begin
        r_head <= 1'b0;
      end else begin
        // Pushes only happen with count<=1, so head^count[0] is always a free slot.
        if (w_push) begin
          r_pc[r_head ^ r_count[0]]    <= r_addr;
          r_instr[r_head ^ r_count[0]] <= imem_data_i;
        end
        if (w_pop)
          r_head <= ~r_head;
      end
    end
  end

  always_comb begin
    imem_req_o    = w_req;
    imem_addr_o   = r_addr;
    instr_valid_o = w_valid;
    instr_o       = '0;
    pc_o          = '0;
    pc_plus4_o    = '0;
    if (w_valid) begin
      instr_o    = r_instr[r_head];
      pc_o       = r_pc[r_head];
      pc_plus4_o = r_pc[r_head] + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns ~address as the instruction word.
module tb_instr_fetch_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic        ack;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] pc;
  } row_t;

  logic        clk, rst, ack, stall, redir;
  logic [31:0] redir_pc;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_o, pc_plus4_o;
  logic [31:0] e_pc, e_p4, e_in;
  int          checks = 0;
  int          errors = 0;

  assign imem_data_i = ~imem_addr_o;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(ack), .imem_data_i(imem_data_i),
    .redirect_i(redir), .redirect_pc_i(redir_pc), .stall_i(stall),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the falling edge of cycle 1 (first cycle after release).
  task automatic do_reset(input logic a, input logic s);
    @(negedge clk);
    rst = 1'b1; ack = a; stall = s; redir = 1'b0; redir_pc = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t rows [4] = '{
      '{H, L, L, 32'h0, H, L, 32'h100, 32'h0},
      '{H, L, L, 32'h0, H, H, 32'h104, 32'h100},
      '{H, L, L, 32'h0, H, H, 32'h108, 32'h104},
      '{H, L, L, 32'h0, H, H, 32'h10C, 32'h108}
    };
    rst = 1'b1; ack = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = '0;
    @(negedge clk);
    checks++;
    if ({imem_req_o, instr_valid_o, imem_addr_o, instr_o, pc_o, pc_plus4_o} !== {2'b00, 32'h100, 96'h0}) begin
      errors++;
      $display("FAIL reset_values: req %b valid %b addr %h instr %h pc %h pc4 %h, expected 0 0 00000100 0 0 0",
               imem_req_o, instr_valid_o, imem_addr_o, instr_o, pc_o, pc_plus4_o);
    end
    rst = 1'b0;
    @(negedge clk);
    foreach (rows[i]) begin
      e_pc = rows[i].valid ? rows[i].pc : '0;
      e_p4 = rows[i].valid ? rows[i].pc + 32'd4 : '0;
      e_in = rows[i].valid ? ~rows[i].pc : '0;
      checks++;
      if (imem_req_o !== rows[i].req || instr_valid_o !== rows[i].valid || (rows[i].req && imem_addr_o !== rows[i].addr) ||
          pc_o !== e_pc || pc_plus4_o !== e_p4 || instr_o !== e_in) begin
        errors++;
        $display("FAIL reset_seq row %0d: req %b valid %b addr %h pc %h pc4 %h instr %h, expected req %b valid %b addr %h pc %h pc4 %h instr %h",
                 i, imem_req_o, instr_valid_o, imem_addr_o, pc_o, pc_plus4_o, instr_o, rows[i].req, rows[i].valid, rows[i].addr, e_pc, e_p4, e_in);
      end
      ack = rows[i].ack; stall = rows[i].stall; redir = rows[i].redir; redir_pc = rows[i].rpc;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    row_t rows [6] = '{
      '{H, H, L, 32'h0, H, L, 32'h100, 32'h0},
      '{H, H, L, 32'h0, H, H, 32'h104, 32'h100},
      '{H, H, L, 32'h0, L, H, 32'h0,   32'h100},
      '{H, L, L, 32'h0, L, H, 32'h0,   32'h100},
      '{H, L, L, 32'h0, H, H, 32'h108, 32'h104},
      '{H, L, L, 32'h0, H, H, 32'h10C, 32'h108}
    };
    do_reset(1'b1, 1'b1);
    foreach (rows[i]) begin
      e_pc = rows[i].valid ? rows[i].pc : '0;
      e_p4 = rows[i].valid ? rows[i].pc + 32'd4 : '0;
      e_in = rows[i].valid ? ~rows[i].pc : '0;
      checks++;
      if (imem_req_o !== rows[i].req || instr_valid_o !== rows[i].valid || (rows[i].req && imem_addr_o !== rows[i].addr) ||
          pc_o !== e_pc || pc_plus4_o !== e_p4 || instr_o !== e_in) begin
        errors++;
        $display("FAIL backpressure row %0d: req %b valid %b addr %h pc %h pc4 %h instr %h, expected req %b valid %b addr %h pc %h pc4 %h instr %h",
                 i, imem_req_o, instr_valid_o, imem_addr_o, pc_o, pc_plus4_o, instr_o, rows[i].req, rows[i].valid, rows[i].addr, e_pc, e_p4, e_in);
      end
      ack = rows[i].ack; stall = rows[i].stall; redir = rows[i].redir; redir_pc = rows[i].rpc;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_wait();
    row_t rows [10] = '{
      '{H, L, L, 32'h0,    H, L, 32'h100,  32'h0},
      '{H, L, L, 32'h0,    H, H, 32'h104,  32'h100},
      '{H, L, L, 32'h0,    H, H, 32'h108,  32'h104},
      '{L, L, L, 32'h0,    H, H, 32'h10C,  32'h108},
      '{L, L, H, 32'h2002, H, L, 32'h10C,  32'h0},
      '{L, L, L, 32'h0,    H, L, 32'h10C,  32'h0},
      '{H, L, L, 32'h0,    H, L, 32'h10C,  32'h0},
      '{H, L, L, 32'h0,    H, L, 32'h2000, 32'h0},
      '{H, L, L, 32'h0,    H, H, 32'h2004, 32'h2000},
      '{H, L, L, 32'h0,    H, H, 32'h2008, 32'h2004}
    };
    do_reset(1'b1, 1'b0);
    foreach (rows[i]) begin
      e_pc = rows[i].valid ? rows[i].pc : '0;
      e_p4 = rows[i].valid ? rows[i].pc + 32'd4 : '0;
      e_in = rows[i].valid ? ~rows[i].pc : '0;
      checks++;
      if (imem_req_o !== rows[i].req || instr_valid_o !== rows[i].valid || (rows[i].req && imem_addr_o !== rows[i].addr) ||
          pc_o !== e_pc || pc_plus4_o !== e_p4 || instr_o !== e_in) begin
        errors++;
        $display("FAIL redirect_wait row %0d: req %b valid %b addr %h pc %h pc4 %h instr %h, expected req %b valid %b addr %h pc %h pc4 %h instr %h",
                 i, imem_req_o, instr_valid_o, imem_addr_o, pc_o, pc_plus4_o, instr_o, rows[i].req, rows[i].valid, rows[i].addr, e_pc, e_p4, e_in);
      end
      ack = rows[i].ack; stall = rows[i].stall; redir = rows[i].redir; redir_pc = rows[i].rpc;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_ack_pop();
    row_t rows [4] = '{
      '{H, L, L, 32'h0,    H, L, 32'h100,  32'h0},
      '{H, L, H, 32'h2000, H, H, 32'h104,  32'h100},
      '{H, L, L, 32'h0,    H, L, 32'h2000, 32'h0},
      '{H, L, L, 32'h0,    H, H, 32'h2004, 32'h2000}
    };
    do_reset(1'b1, 1'b0);
    foreach (rows[i]) begin
      e_pc = rows[i].valid ? rows[i].pc : '0;
      e_p4 = rows[i].valid ? rows[i].pc + 32'd4 : '0;
      e_in = rows[i].valid ? ~rows[i].pc : '0;
      checks++;
      if (imem_req_o !== rows[i].req || instr_valid_o !== rows[i].valid || (rows[i].req && imem_addr_o !== rows[i].addr) ||
          pc_o !== e_pc || pc_plus4_o !== e_p4 || instr_o !== e_in) begin
        errors++;
        $display("FAIL redirect_ack_pop row %0d: req %b valid %b addr %h pc %h pc4 %h instr %h, expected req %b valid %b addr %h pc %h pc4 %h instr %h",
                 i, imem_req_o, instr_valid_o, imem_addr_o, pc_o, pc_plus4_o, instr_o, rows[i].req, rows[i].valid, rows[i].addr, e_pc, e_p4, e_in);
      end
      ack = rows[i].ack; stall = rows[i].stall; redir = rows[i].redir; redir_pc = rows[i].rpc;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    row_t rows [5] = '{
      '{H, L, H, 32'hFFFF_FFF8, H, L, 32'h100,       32'h0},
      '{H, L, L, 32'h0,         H, L, 32'hFFFF_FFF8, 32'h0},
      '{H, L, L, 32'h0,         H, H, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
      '{H, L, L, 32'h0,         H, H, 32'h0000_0000, 32'hFFFF_FFFC},
      '{H, L, L, 32'h0,         H, H, 32'h0000_0004, 32'h0000_0000}
    };
    do_reset(1'b1, 1'b0);
    foreach (rows[i]) begin
      e_pc = rows[i].valid ? rows[i].pc : '0;
      e_p4 = rows[i].valid ? rows[i].pc + 32'd4 : '0;
      e_in = rows[i].valid ? ~rows[i].pc : '0;
      checks++;
      if (imem_req_o !== rows[i].req || instr_valid_o !== rows[i].valid || (rows[i].req && imem_addr_o !== rows[i].addr) ||
          pc_o !== e_pc || pc_plus4_o !== e_p4 || instr_o !== e_in) begin
        errors++;
        $display("FAIL wrap row %0d: req %b valid %b addr %h pc %h pc4 %h instr %h, expected req %b valid %b addr %h pc %h pc4 %h instr %h",
                 i, imem_req_o, instr_valid_o, imem_addr_o, pc_o, pc_plus4_o, instr_o, rows[i].req, rows[i].valid, rows[i].addr, e_pc, e_p4, e_in);
      end
      ack = rows[i].ack; stall = rows[i].stall; redir = rows[i].redir; redir_pc = rows[i].rpc;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL async_prefill: valid %b pc %h req %b, expected 1 00000100 0", instr_valid_o, pc_o, imem_req_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, instr_valid_o, imem_addr_o, instr_o, pc_o, pc_plus4_o} !== {2'b00, 32'h100, 96'h0}) begin
      errors++;
      $display("FAIL async_reset_values: req %b valid %b addr %h instr %h pc %h pc4 %h, expected 0 0 00000100 0 0 0",
               imem_req_o, instr_valid_o, imem_addr_o, instr_o, pc_o, pc_plus4_o);
    end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; ack = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_restart_req: req %b addr %h valid %b, expected 1 00000100 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    @(negedge clk);
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== ~32'h100 || imem_addr_o !== 32'h104) begin
      errors++;
      $display("FAIL async_restart_data: valid %b pc %h instr %h addr %h, expected 1 00000100 fffffeff 00000104",
               instr_valid_o, pc_o, instr_o, imem_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
